// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite encodings, slave FSM states and the
//                transfer-legality / byte-strobe helpers used by the memory
//                slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  // Transfer type as driven by the master
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Transfer sizes supported by a 32-bit slave
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase state of the slave
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  // Wider than a word, or not naturally aligned to its own size
  function automatic logic ahb_illegal(input logic [2:0] size, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (size > HSIZE_WORD)                       bad = 1'b1;
    else if ((size == HSIZE_HALF) && a[0])       bad = 1'b1;
    else if ((size == HSIZE_WORD) && (a != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

  // Byte lanes touched by a legal transfer
  function automatic logic [3:0] ahb_strobes(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << a;
      HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: s = 4'b1111;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_array
//  Description : MEM_WORDS x 32 single-clock SRAM with one synchronous read
//                port and one byte-maskable write port. Reads return the
//                contents from before a same-edge write; contents are not
//                reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_array #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data,
  input  logic [3:0]    i_wr_be,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rd_data;

  // Storage update per byte lane plus registered read of the old word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_wr_be[i]) r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
    end
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem_ctrl
//  Description : AHB-Lite slave in front of a word-organised SRAM. Latches
//                address phases, inserts WAIT_STATES wait cycles, commits
//                strobed writes at the end of the data phase, returns read
//                words (with same-edge write forwarding) and produces the
//                two-cycle ERROR response for illegal size/alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mem_ctrl
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  output logic [31:0] hr_data,
  output logic        hready,
  output logic        hresp
);

  localparam int         AW        = $clog2(MEM_WORDS);
  localparam logic [3:0] C_WS      = 4'(WAIT_STATES);
  localparam logic       C_ZERO_WS = (WAIT_STATES == 0);

  // FSM and registered bus outputs
  slv_state_e  r_state;
  logic [3:0]  r_cnt;
  logic        r_hready;
  logic        r_hresp;

  // Latched address-phase control
  logic [AW-1:0] r_idx;
  logic          r_write;
  logic [3:0]    r_strb;

  // Read-return registers
  logic          r_rd_valid;
  logic          r_fwd;
  logic [31:0]   r_fwd_data;
  logic [3:0]    r_fwd_strb;

  logic [AW-1:0] w_haddr_idx;
  logic          w_accept;
  logic          w_illegal;
  logic          w_rd_now;
  logic          w_rd_wait;
  logic          w_rd_load;
  logic [AW-1:0] w_rd_addr;
  logic          w_commit;
  logic [3:0]    w_wr_be;
  logic          w_fwd;
  logic [31:0]   w_sram_rdata;
  logic [31:0]   w_merged;
  logic          w_unused;

  assign w_haddr_idx = haddr[AW+1:2];
  assign w_accept    = hsel & r_hready &
                       ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign w_illegal   = ahb_illegal(hsize, haddr[1:0]);

  // A read enters LAST either straight from the address edge (no wait
  // states, address still on the bus) or from the final WAIT cycle
  // (address taken from the latch).
  assign w_rd_now  = w_accept & ~w_illegal & C_ZERO_WS & ~hwrite;
  assign w_rd_wait = (r_state == ST_WAIT) & (r_cnt <= 4'd1) & ~r_write;
  assign w_rd_load = w_rd_now | w_rd_wait;
  assign w_rd_addr = w_rd_now ? w_haddr_idx : r_idx;

  // Writes land on the edge that closes the LAST cycle
  assign w_commit = (r_state == ST_LAST) & r_write;
  assign w_wr_be  = w_commit ? r_strb : 4'b0000;

  // The SRAM returns pre-write data, so remember the committing lanes
  assign w_fwd = w_commit & w_rd_now & (w_haddr_idx == r_idx);

  assign w_unused = ^{hprot, haddr};

  ahb_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_sram (
    .clk       (clk),
    .i_rd_en   (w_rd_load),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_sram_rdata),
    .i_wr_be   (w_wr_be),
    .i_wr_addr (r_idx),
    .i_wr_data (hwdata)
  );

  // Capture address-phase control whenever a transfer is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_strb  <= 4'b0000;
    end else if (w_accept) begin
      r_idx   <= w_haddr_idx;
      r_write <= hwrite;
      r_strb  <= ahb_strobes(hsize, haddr[1:0]);
    end
  end

  // Data-phase FSM with Moore-registered hready/hresp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state  <= ST_LAST;
            r_cnt    <= 4'd0;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        default: begin
          // IDLE, LAST and ERR2 all hand straight over to the next transfer
          if (w_accept) begin
            if (w_illegal) begin
              r_state  <= ST_ERR1;
              r_cnt    <= 4'd0;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_ERROR;
            end else if (C_ZERO_WS) begin
              r_state  <= ST_LAST;
              r_cnt    <= 4'd0;
              r_hready <= 1'b1;
              r_hresp  <= HRESP_OKAY;
            end else begin
              r_state  <= ST_WAIT;
              r_cnt    <= C_WS;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_OKAY;
            end
          end else begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Track what the read port loaded and which lanes need forwarding
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= 32'h0;
      r_fwd_strb <= 4'b0000;
    end else if (w_rd_load) begin
      r_rd_valid <= 1'b1;
      r_fwd      <= w_fwd;
      r_fwd_data <= hwdata;
      r_fwd_strb <= r_strb;
    end
  end

  // Overlay forwarded write lanes on the pre-write SRAM word
  always_comb begin
    w_merged = w_sram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_fwd && r_fwd_strb[i]) w_merged[8*i +: 8] = r_fwd_data[8*i +: 8];
    end
  end

  assign hr_data = r_rd_valid ? w_merged : 32'h0;
  assign hready  = r_hready;
  assign hresp   = r_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_slave_mem_ctrl
//  Description : Self-checking bench for ahb_slave_mem_ctrl. Two instances
//                (one and zero wait states) are driven by a pipelined AHB
//                master with directed and random transfers and compared
//                against a byte-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem_ctrl;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       hsel;
  logic [1:0]       hwrite;
  logic [1:0][1:0]  htrans;
  logic [1:0][2:0]  hsize;
  logic [1:0][3:0]  hprot;
  logic [1:0][31:0] haddr;
  logic [1:0][31:0] hwdata;
  logic [31:0]      hrd0, hrd1;
  logic             hrdy0, hrdy1, hrsp0, hrsp1;

  ahb_slave_mem_ctrl #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset_n(rst_n[0]), .hsel(hsel[0]), .haddr(haddr[0]),
    .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hprot(hprot[0]),
    .hwdata(hwdata[0]), .hr_data(hrd0), .hready(hrdy0), .hresp(hrsp0)
  );

  ahb_slave_mem_ctrl #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset_n(rst_n[1]), .hsel(hsel[1]), .haddr(haddr[1]),
    .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hprot(hprot[1]),
    .hwdata(hwdata[1]), .hr_data(hrd1), .hready(hrdy1), .hresp(hrsp1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          ws_of [2] = '{1, 0};
  logic [31:0] mem_m [2][1024];
  xfer_t       xq[$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic xfer_t mk(input bit sel, input logic [1:0] tr, input bit wr,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd;
    x.chk = 1'b0; x.exp = 32'h0;
    return x;
  endfunction

  function automatic xfer_t mk_lw(input logic [31:0] a, input logic [31:0] e);
    xfer_t x;
    x = mk(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0);
    x.chk = 1'b1; x.exp = e;
    return x;
  endfunction

  // Reference rules: a transfer is legal if at most a word and aligned to its size
  function automatic bit is_legal(input xfer_t x);
    return (x.size <= 3'd2) && ((x.addr % (32'd1 << x.size)) == 32'd0);
  endfunction

  function automatic bit is_active(input xfer_t x);
    return x.sel && x.trans[1];
  endfunction

  task automatic model_write(input int d, input xfer_t x);
    logic [31:0] w;
    int          nbytes;
    int          lane;
    w      = mem_m[d][x.addr[11:2]];
    nbytes = 1 << x.size;
    for (int k = 0; k < nbytes; k++) begin
      lane = int'(x.addr[1:0]) + k;
      w[8*lane +: 8] = x.wdata[8*lane +: 8];
    end
    mem_m[d][x.addr[11:2]] = w;
  endtask

  task automatic drive(input int d, input xfer_t x, input logic [31:0] wd);
    hsel[d]   = x.sel;
    htrans[d] = x.trans;
    hwrite[d] = x.wr;
    hsize[d]  = x.size;
    haddr[d]  = x.addr;
    hprot[d]  = 4'($urandom);
    hwdata[d] = wd;
  endtask

  task automatic sample(input int d, output logic rdy, output logic rsp, output logic [31:0] rd);
    rdy = (d == 0) ? hrdy0 : hrdy1;
    rsp = (d == 0) ? hrsp0 : hrsp1;
    rd  = (d == 0) ? hrd0  : hrd1;
  endtask

  // Pipelined master: address phase of the queue head overlaps the data phase of the previous transfer
  task automatic run_seq(input int d);
    xfer_t       dp, ap;
    bit          dp_v;
    bit          err;
    int          cyc;
    int          guard;
    logic        rdy, rsp;
    logic [31:0] rd;
    dp_v  = 1'b0;
    cyc   = 0;
    guard = 0;
    dp    = mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    while (xq.size() > 0 || dp_v) begin
      @(posedge clk); #1;
      if (xq.size() > 0) ap = xq[0];
      else ap = mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
      drive(d, ap, (dp_v && dp.wr) ? dp.wdata : $urandom());
      @(negedge clk);
      sample(d, rdy, rsp, rd);
      guard++;
      if (dp_v) begin
        cyc++;
        err = is_active(dp) && !is_legal(dp);
        chk_val("hresp", 32'(rsp), 32'(err));
        if (rdy) begin
          chk_val("latency", 32'(cyc), !is_active(dp) ? 32'd1 : err ? 32'd2 : 32'(ws_of[d] + 1));
          if (is_active(dp) && !err && !dp.wr) begin
            chk_val("rdata_model", rd, mem_m[d][dp.addr[11:2]]);
            if (dp.chk) chk_val("rdata_expected", rd, dp.exp);
          end
          if (is_active(dp) && !err && dp.wr) model_write(d, dp);
          dp_v = 1'b0;
        end else if (cyc >= 20) begin
          chk_val("hready_timeout", 32'(rdy), 32'd1);
          xq.delete();
          return;
        end
      end else begin
        chk_val("no_dataphase_ready_okay", {30'd0, rdy, rsp}, 32'd2);
      end
      if (guard > 20000) begin
        chk_val("sequence_guard", 32'(rdy), 32'd1);
        xq.delete();
        return;
      end
      if (rdy && xq.size() > 0) begin
        dp   = xq.pop_front();
        dp_v = 1'b1;
        cyc  = 0;
      end
    end
  endtask

  task automatic init_region(input int d);
    for (int w = 0; w < 8; w++) xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h100 + 32'(w*4), $urandom()));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h0));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h0));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0));
    run_seq(d);
  endtask

  task automatic gen_random(input int n);
    for (int i = 0; i < n; i++) begin
      int          r;
      logic [2:0]  sz;
      logic [31:0] a;
      xfer_t       x;
      r  = $urandom_range(0, 99);
      sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = 32'h100 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 3'd0)           a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 3'd1)           a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      x = mk(1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz, a, $urandom());
      if (r < 10) begin
        x.trans = 2'($urandom_range(0, 1));
        x.addr  = $urandom();
      end else if (r < 18) begin
        x.sel  = 1'b0;
        x.wr   = 1'b1;
        x.addr = $urandom();
      end
      xq.push_back(x);
    end
  endtask

  initial begin
    logic [31:0] hrd_v;
    rst_n = 2'b00;
    drive(0, mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0), 32'h0);
    drive(1, mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_hready_ws1", 32'(hrdy0), 32'd1);
    chk_val("reset_hresp_ws1",  32'(hrsp0), 32'd0);
    chk_val("reset_hrdata_ws1", hrd0, 32'h0);
    chk_val("reset_hready_ws0", 32'(hrdy1), 32'd1);
    chk_val("reset_hresp_ws0",  32'(hrsp1), 32'd0);
    chk_val("reset_hrdata_ws0", hrd1, 32'h0);
    @(negedge clk);
    rst_n = 2'b11;

    // ---------------- one wait state ----------------
    init_region(0);
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h1234_5678));
    xq.push_back(mk_lw(32'h10, 32'h1234_5678));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h1122_3344));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h13, 32'hAB00_0000));
    xq.push_back(mk_lw(32'h10, 32'hAB22_3344));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h12, 32'hBEEF_0000));
    xq.push_back(mk_lw(32'h10, 32'hBEEF_3344));
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 3'd1, 32'h11, 32'h0));
    xq.push_back(mk_lw(32'h10, 32'hBEEF_3344));
    xq.push_back(mk(1'b1, 2'b00, 1'b1, 3'd2, 32'hFFFF_F010, 32'h0));
    xq.push_back(mk(1'b0, 2'b10, 1'b1, 3'd2, 32'hFFFF_F010, 32'h0));
    xq.push_back(mk_lw(32'h10, 32'hBEEF_3344));
    run_seq(0);
    gen_random(300);
    run_seq(0);

    // Reset in the middle of a write's wait state
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h5A5A_5A5A));
    run_seq(0);
    @(posedge clk); #1;
    drive(0, mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 32'h0), 32'h0);
    @(posedge clk); #1;
    drive(0, mk(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0), 32'hDEAD_BEEF);
    @(negedge clk);
    chk_val("abort_in_wait_hready", 32'(hrdy0), 32'd0);
    rst_n[0] = 1'b0;
    #1;
    hrd_v = hrd0;
    chk_val("abort_hready", 32'(hrdy0), 32'd1);
    chk_val("abort_hresp",  32'(hrsp0), 32'd0);
    chk_val("abort_hrdata", hrd_v, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    xq.push_back(mk_lw(32'h30, 32'h5A5A_5A5A));
    run_seq(0);

    // ---------------- zero wait states ----------------
    init_region(1);
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D));
    xq.push_back(mk_lw(32'h20, 32'hCAFE_F00D));
    xq.push_back(mk(1'b1, 2'b11, 1'b1, 3'd1, 32'h22, 32'h1234_0000));
    xq.push_back(mk_lw(32'h20, 32'h1234_F00D));
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h22, 32'h0));
    xq.push_back(mk_lw(32'h20, 32'h1234_F00D));
    run_seq(1);
    gen_random(400);
    run_seq(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
